// File: rtl/dcache_direct_wt_if.sv
// Bundles for the data-cache: dcache_if between memory stage and cache,
// dmem_if between cache and the word-wide backing memory.
interface dcache_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              write_en;
    logic [31:0]       write_data;
    logic [1:0]        size;
    logic              sign;
    logic              resp_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;

    // Request is offered with req_valid and held stable by the master until a clock edge
    // sees req_valid && resp_ready; completion is a one-cycle resp_valid pulse.
    modport master (
        output req_valid, req_addr, write_en, write_data, size, sign,
        input  resp_ready, resp_valid, resp_data
    );
    modport slave (
        input  req_valid, req_addr, write_en, write_data, size, sign,
        output resp_ready, resp_valid, resp_data
    );
endinterface

interface dmem_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_direct_wt.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// with B/H/W sizing, load sign extension and store byte-lane steering.
module dcache_direct_wt #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    dcache_if.slave    cpu,
    dmem_if.master     mem,
    output logic [1:0] fsm_state
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] MEM_RD = 2'd2;
    localparam logic [1:0] MEM_WR = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [31:0]       lat_wdata;
    logic [1:0]        lat_size;
    logic              lat_sign;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [31:0]       hit_word;
    logic [31:0]       merged_word;
    logic [31:0]       ld_src;
    logic [31:0]       ld_result;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic              line_fill;
    logic              line_merge;

    assign fsm_state = state;

    assign idx      = lat_addr[IDX_W+1:2];
    assign tag      = lat_addr[ADDR_W-1:IDX_W+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_word = data_q[idx];

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        sgn
    );
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (sz)
            MEM_SIZE_B: load_extract = {{24{sgn & b[7]}}, b};
            MEM_SIZE_H: load_extract = {{16{sgn & h[15]}}, h};
            default:    load_extract = word;
        endcase
    endfunction

    assign ld_src    = (state == MEM_RD) ? mem.mem_rdata : hit_word;
    assign ld_result = load_extract(ld_src, lat_addr[1:0], lat_size, lat_sign);

    always_comb begin
        st_wdata = lat_wdata;
        st_wstrb = 4'hF;
        case (lat_size)
            MEM_SIZE_B: begin
                st_wdata = {4{lat_wdata[7:0]}};
                st_wstrb = 4'b0001 << lat_addr[1:0];
            end
            MEM_SIZE_H: begin
                st_wdata = {2{lat_wdata[15:0]}};
                st_wstrb = lat_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // The registered strobes/data on the memory port are exactly what the store
    // puts in memory, so the line merge reuses them.
    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (mem.mem_wstrb[b]) begin
                merged_word[8*b +: 8] = mem.mem_wdata[8*b +: 8];
            end
        end
    end

    assign line_fill  = (state == MEM_RD) && mem.mem_ack;
    assign line_merge = (state == MEM_WR) && mem.mem_ack && hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (line_fill) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem.mem_rdata;
            end else if (line_merge) begin
                data_q[idx] <= merged_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            valid_q        <= '0;
            lat_addr       <= '0;
            lat_we         <= 1'b0;
            lat_wdata      <= '0;
            lat_size       <= '0;
            lat_sign       <= 1'b0;
            cpu.resp_ready <= 1'b1;
            cpu.resp_valid <= 1'b0;
            cpu.resp_data  <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            mem.mem_wstrb  <= '0;
        end else begin
            cpu.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.req_valid && cpu.resp_ready) begin
                        lat_addr       <= cpu.req_addr;
                        lat_we         <= cpu.write_en;
                        lat_wdata      <= cpu.write_data;
                        lat_size       <= cpu.size;
                        lat_sign       <= cpu.sign;
                        cpu.resp_ready <= 1'b0;
                        state          <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lat_we) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= lat_addr[ADDR_W-1:2];
                        mem.mem_wdata <= st_wdata;
                        mem.mem_wstrb <= st_wstrb;
                        state         <= MEM_WR;
                    end else if (hit) begin
                        cpu.resp_valid <= 1'b1;
                        cpu.resp_data  <= ld_result;
                        cpu.resp_ready <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= lat_addr[ADDR_W-1:2];
                        mem.mem_wstrb <= 4'hF;
                        state         <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem.mem_ack) begin
                        valid_q[idx]   <= 1'b1;
                        cpu.resp_valid <= 1'b1;
                        cpu.resp_data  <= ld_result;
                        cpu.resp_ready <= 1'b1;
                        mem.mem_req    <= 1'b0;
                        mem.mem_wstrb  <= '0;
                        state          <= IDLE;
                    end
                end
                MEM_WR: begin
                    if (mem.mem_ack) begin
                        cpu.resp_valid <= 1'b1;
                        cpu.resp_data  <= '0;
                        cpu.resp_ready <= 1'b1;
                        mem.mem_req    <= 1'b0;
                        mem.mem_we     <= 1'b0;
                        mem.mem_wstrb  <= '0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
